// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with a memory
// handshake, a stall timeout that traps, and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               PCSource,
    output logic [ALUOP_W-1:0] ALU_op,
    output logic [2:0]         state,
    output logic               trap,
    output logic [CNT_W-1:0]   instr_count
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q, func_q;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]   to_inc;
    logic              to_hit;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    logic              legal;
    logic [2:0]        alu3;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (func == F_ADD) || (func == F_SUB) || (func == F_AND) ||
                              (func == F_OR)  || (func == F_XOR);
            OP_LW, OP_SW, OP_BEQ, OP_LUI: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    assign to_inc = to_cnt_q + TO_W'(1);
    assign to_hit = (to_inc == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        retire   = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d  = S_DECODE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_inc;
                    if (to_hit) state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_LUI: state_d = S_WB;
                    OP_LW, OP_SW:     state_d = S_MEM;
                    OP_BEQ: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    to_cnt_d = '0;
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_inc;
                    if (to_hit) state_d = S_TRAP;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_TRAP;
        endcase
        // Each memory access gets its own full timeout window.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            to_cnt_d = '0;
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            func_q   <= '0;
            to_cnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            cnt_q    <= cnt_d;
            if (state_q == S_DECODE) begin
                op_q   <= op;
                func_q <= func;
            end
        end
    end

    // Outputs decode from the registered state so an async reset zeroes them at once.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        PCSource = 1'b0;
        alu3     = 3'b000;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        ALUSrcA = 1'b1;
                        case (func_q)
                            F_SUB:   alu3 = 3'b001;
                            F_AND:   alu3 = 3'b010;
                            F_OR:    alu3 = 3'b011;
                            F_XOR:   alu3 = 3'b100;
                            default: alu3 = 3'b000;
                        endcase
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 2'b10;
                    end
                    OP_BEQ: begin
                        ALUSrcA  = 1'b1;
                        alu3     = 3'b001;
                        PCSource = 1'b1;
                        PCWrite  = zero;
                    end
                    OP_LUI: begin
                        ALUSrcB = 2'b10;
                        alu3    = 3'b101;
                    end
                    default: alu3 = 3'b000;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_RTYPE);
                MemtoReg = (op_q == OP_LW);
            end
            default: alu3 = 3'b000;
        endcase
    end

    assign ALU_op      = ALUOP_W'(alu3);
    assign state       = state_q;
    assign trap        = (state_q == S_TRAP);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed + randomized bench for multicycle_control_unit; a per-instruction phase
// model predicts every cycle's control word and the retired count.
module tb_multicycle_control_unit;
    localparam int CW = 4;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] LUI = 6'b001111;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3,
                   PH_MEM = 4, PH_WB = 5, PH_TRAP = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    op = '0, func = '0;
    logic          zero = 1'b0, mem_ready = 1'b0;
    logic          PCWrite, IorD, IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic          MemRead, MemWrite, MemtoReg, PCSource;
    logic [2:0]    ALU_op;
    logic [2:0]    state;
    logic          trap;
    logic [CW-1:0] instr_count;
    logic [18:0]   obs;

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    multicycle_control_unit #(.ALUOP_W(3), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCSource(PCSource), .ALU_op(ALU_op),
        .state(state), .trap(trap), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs = {state, trap, PCWrite, IorD, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                  MemRead, MemWrite, MemtoReg, PCSource, ALU_op};

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected control word for one cycle of a given phase of instruction opc/fn.
    function automatic logic [18:0] model_out(input int ph, input logic [5:0] opc,
                                              input logic [5:0] fn, input logic mr,
                                              input logic z);
        logic pcw, iord, irw, rdst, rw, asa, mrd, mwr, m2r, pcs, trp;
        logic [1:0] asb;
        logic [2:0] alu;
        {pcw, iord, irw, rdst, rw, asa, mrd, mwr, m2r, pcs, trp} = '0;
        asb = 2'b00;
        alu = 3'b000;
        if (ph == PH_FETCH) begin
            mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr;
        end else if (ph == PH_DECODE) begin
            asb = 2'b11;
        end else if (ph == PH_EXEC) begin
            if (opc == 6'b000000) begin
                asa = 1'b1;
                if (fn == 6'd34)      alu = 3'd1;
                else if (fn == 6'd36) alu = 3'd2;
                else if (fn == 6'd37) alu = 3'd3;
                else if (fn == 6'd38) alu = 3'd4;
            end else if (opc == LW || opc == SW) begin
                asa = 1'b1; asb = 2'b10;
            end else if (opc == BEQ) begin
                asa = 1'b1; alu = 3'd1; pcs = 1'b1; pcw = z;
            end else if (opc == LUI) begin
                asb = 2'b10; alu = 3'd5;
            end
        end else if (ph == PH_MEM) begin
            iord = 1'b1; mrd = (opc == LW); mwr = (opc == SW);
        end else if (ph == PH_WB) begin
            rw = 1'b1; rdst = (opc == 6'b000000); m2r = (opc == LW);
        end else if (ph == PH_TRAP) begin
            trp = 1'b1;
        end
        return {3'(ph), trp, pcw, iord, irw, rdst, rw, asa, asb, mrd, mwr, m2r, pcs, alu};
    endfunction

    // Drive one cycle's inputs, compare at the falling edge, then move just past the next rising edge.
    task automatic step(input logic [18:0] exp, input logic mr, input logic z, input string tag);
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        checks++;
        assert (instr_count === CW'(retired % (1 << CW))) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, instr_count, retired % (1 << CW));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; op = '0; func = '0; mem_ready = 1'b0; zero = 1'b0;
        #3;
        checks++;
        assert (obs === 19'd0 && instr_count === '0) else begin
            errors++;
            $error("FAIL reset observed=%h/%0d expected=0/0", obs, instr_count);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        retired = 0;
        step(model_out(PH_IDLE, 6'd0, 6'd0, 1'b0, 1'b0), rb(), rb(), "idle");
    endtask

    // Runs one legal instruction from the start of its FETCH through retirement.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fst,
                             input int mst, input logic z);
        op = opc; func = fn;
        for (int i = 0; i < fst; i++)
            step(model_out(PH_FETCH, opc, fn, 1'b0, 1'b0), 1'b0, rb(), "fetch_stall");
        step(model_out(PH_FETCH, opc, fn, 1'b1, 1'b0), 1'b1, rb(), "fetch");
        step(model_out(PH_DECODE, opc, fn, 1'b0, 1'b0), rb(), rb(), "decode");
        op = 6'($urandom); func = 6'($urandom);
        step(model_out(PH_EXEC, opc, fn, 1'b0, z), rb(), z, "exec");
        if (opc == LW || opc == SW) begin
            for (int i = 0; i < mst; i++)
                step(model_out(PH_MEM, opc, fn, 1'b0, 1'b0), 1'b0, rb(), "mem_stall");
            step(model_out(PH_MEM, opc, fn, 1'b1, 1'b0), 1'b1, rb(), "mem");
        end
        if (opc == 6'b000000 || opc == LW || opc == LUI)
            step(model_out(PH_WB, opc, fn, 1'b0, 1'b0), rb(), rb(), "wb");
        retired++;
        check_count("instr_count");
        checks++;
        assert (state === 3'd1) else begin
            errors++;
            $error("FAIL refetch observed=%0d expected=1", state);
        end
    endtask

    task automatic hold_trap(input string tag);
        int frozen;
        frozen = retired;
        for (int i = 0; i < 4; i++)
            step(model_out(PH_TRAP, 6'd0, 6'd0, 1'b0, 1'b0), rb(), rb(), tag);
        retired = frozen;
        check_count("trap_count_frozen");
    endtask

    task automatic run_illegal(input logic [5:0] opc, input logic [5:0] fn);
        op = opc; func = fn;
        step(model_out(PH_FETCH, opc, fn, 1'b1, 1'b0), 1'b1, rb(), "fetch");
        step(model_out(PH_DECODE, opc, fn, 1'b0, 1'b0), rb(), rb(), "decode_illegal");
        hold_trap("illegal_trap");
    endtask

    task automatic run_random();
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        logic [5:0] o, f;
        int fst, mst;
        ops = '{6'd0, 6'd0, 6'd0, LW, SW, BEQ, LUI};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38};
        o   = ops[$urandom_range(0, 6)];
        f   = (o == 6'd0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
        fst = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
        mst = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
        run_instr(o, f, fst, mst, rb());
    endtask

    initial begin
        do_reset();
        // R-type add, then each remaining function
        run_instr(6'd0, 6'b100000, 0, 0, 1'b0);
        run_instr(6'd0, 6'b100010, 0, 0, 1'b1);
        run_instr(6'd0, 6'b100100, 0, 0, 1'b0);
        run_instr(6'd0, 6'b100101, 0, 0, 1'b0);
        run_instr(6'd0, 6'b100110, 0, 0, 1'b1);
        run_instr(LW, 6'd0, 0, 3, 1'b0);
        run_instr(BEQ, 6'd0, 0, 0, 1'b1);
        run_instr(BEQ, 6'd0, 0, 0, 1'b0);
        run_instr(SW, 6'd0, 0, 0, 1'b0);
        run_instr(LUI, 6'd0, 0, 0, 1'b0);
        // Stall one short of the limit: the ready on the last cycle wins
        run_instr(SW, 6'd0, 14, 14, 1'b0);
        run_instr(LW, 6'd0, 2, 14, 1'b1);

        // Counter wrap at CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) run_random();
        checks++;
        assert (instr_count === 4'd1) else begin
            errors++;
            $error("FAIL wrap17 observed=%0d expected=1", instr_count);
        end
        for (int i = 0; i < 30; i++) run_random();

        do_reset();
        run_instr(LUI, 6'd0, 0, 0, 1'b0);
        run_illegal(6'b000010, 6'd0);
        do_reset();
        run_illegal(6'd0, 6'b101010);

        // FETCH timeout
        do_reset();
        run_instr(BEQ, 6'd0, 1, 0, 1'b1);
        for (int i = 0; i < 15; i++)
            step(model_out(PH_FETCH, 6'd0, 6'd0, 1'b0, 1'b0), 1'b0, rb(), "fetch_timeout");
        hold_trap("fetch_trap");

        // MEM timeout on lw
        do_reset();
        op = LW; func = 6'd0;
        step(model_out(PH_FETCH, LW, 6'd0, 1'b1, 1'b0), 1'b1, rb(), "fetch");
        step(model_out(PH_DECODE, LW, 6'd0, 1'b0, 1'b0), rb(), rb(), "decode");
        step(model_out(PH_EXEC, LW, 6'd0, 1'b0, 1'b0), rb(), rb(), "exec");
        for (int i = 0; i < 15; i++)
            step(model_out(PH_MEM, LW, 6'd0, 1'b0, 1'b0), 1'b0, rb(), "mem_timeout");
        hold_trap("mem_trap");

        // Reset in the middle of a sw memory phase
        do_reset();
        op = SW; func = 6'd0;
        step(model_out(PH_FETCH, SW, 6'd0, 1'b1, 1'b0), 1'b1, rb(), "fetch");
        step(model_out(PH_DECODE, SW, 6'd0, 1'b0, 1'b0), rb(), rb(), "decode");
        step(model_out(PH_EXEC, SW, 6'd0, 1'b0, 1'b0), rb(), rb(), "exec");
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        assert (obs === model_out(PH_MEM, SW, 6'd0, 1'b0, 1'b0)) else begin
            errors++;
            $error("FAIL sw_mem observed=%h expected=%h", obs,
                   model_out(PH_MEM, SW, 6'd0, 1'b0, 1'b0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (MemWrite === 1'b0 && obs === 19'd0 && instr_count === '0) else begin
            errors++;
            $error("FAIL abort_reset observed=%h/%0d expected=0/0", obs, instr_count);
        end
        do_reset();
        run_instr(6'd0, 6'b100000, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
